// File: rtl/conv_intrm_acc_buf.sv
`default_nettype none
// ============================================================================
// Module      : conv_intrm_acc_buf
// Description : Intermediate buffer/accumulator between the conv multiplier
//               array and the next stage; pass/extend or ACC_LEN-beat sum.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_intrm_acc_buf #(
    parameter int NUM_INPUTS   = 5,
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH,
    parameter int ACC_LEN      = 5,
    parameter int SIGNED       = 1
) (
    input  logic                               intrm_acc_clk,
    input  logic                               intrm_acc_rst,
    input  logic                               intrm_acc_en_i,
    input  logic                               intrm_acc_mode_i,
    input  logic                               intrm_acc_in_valid_i,
    output logic                               intrm_acc_in_ready_o,
    input  logic [NUM_INPUTS*INPUT_WIDTH-1:0]  intrm_acc_in_i,
    output logic                               intrm_acc_out_valid_o,
    input  logic                               intrm_acc_out_ready_i,
    output logic [NUM_INPUTS*OUTPUT_WIDTH-1:0] intrm_acc_out_o,
    output logic [$clog2(ACC_LEN)-1:0]         intrm_acc_beat_cnt_o,
    output logic                               intrm_acc_ovf_o
);

    localparam int              c_CW     = $clog2(ACC_LEN);
    localparam int              c_OW_TOT = NUM_INPUTS * OUTPUT_WIDTH;
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(ACC_LEN - 1);

    logic                  r_mode;
    logic [c_CW-1:0]       r_beat_cnt;
    logic [c_OW_TOT-1:0]   r_acc;
    logic [c_OW_TOT-1:0]   r_out;
    logic                  r_out_valid;
    logic                  r_ovf;

    logic                  w_first;
    logic                  w_eff_mode;
    logic                  w_final;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [c_OW_TOT-1:0]   w_sum;
    logic [NUM_INPUTS-1:0] w_ch_ovf;

    // Mode is only taken from the port at the start of a group.
    assign w_first    = (r_beat_cnt == '0);
    assign w_eff_mode = w_first ? intrm_acc_mode_i : r_mode;
    assign w_final    = !w_eff_mode || (r_beat_cnt == c_LAST);
    assign w_in_ready = intrm_acc_en_i && !intrm_acc_rst &&
                        (!w_final || !r_out_valid || intrm_acc_out_ready_i);
    assign w_accept   = intrm_acc_in_valid_i && w_in_ready;

    generate
        for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
            logic [INPUT_WIDTH-1:0]  w_in;
            logic [OUTPUT_WIDTH-1:0] w_ext;
            logic [OUTPUT_WIDTH-1:0] w_base;
            logic [OUTPUT_WIDTH:0]   w_wide;
            logic                    w_sgn_ovf;

            assign w_in = intrm_acc_in_i[g*INPUT_WIDTH +: INPUT_WIDTH];

            if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_ext
                logic w_fill;
                assign w_fill = (SIGNED != 0) ? w_in[INPUT_WIDTH-1] : 1'b0;
                assign w_ext  = {{(OUTPUT_WIDTH-INPUT_WIDTH){w_fill}}, w_in};
            end else begin : g_id
                assign w_ext = w_in;
            end

            // A zero base on the first beat turns the add into a plain load.
            assign w_base    = w_first ? '0 : r_acc[g*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            assign w_wide    = {1'b0, w_base} + {1'b0, w_ext};
            assign w_sgn_ovf = (w_base[OUTPUT_WIDTH-1] == w_ext[OUTPUT_WIDTH-1]) &&
                               (w_wide[OUTPUT_WIDTH-1] != w_base[OUTPUT_WIDTH-1]);
            assign w_ch_ovf[g] = (SIGNED != 0) ? w_sgn_ovf : w_wide[OUTPUT_WIDTH];
            assign w_sum[g*OUTPUT_WIDTH +: OUTPUT_WIDTH] = w_wide[OUTPUT_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge intrm_acc_clk) begin
        if (intrm_acc_rst) begin
            r_mode      <= 1'b0;
            r_beat_cnt  <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_mode <= intrm_acc_mode_i;
                end
                if (w_final) begin
                    r_out      <= w_sum;
                    r_beat_cnt <= '0;
                end else begin
                    r_acc      <= w_sum;
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                if (|w_ch_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
            // A new result wins over draining the held one.
            if (w_accept && w_final) begin
                r_out_valid <= 1'b1;
            end else if (intrm_acc_out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign intrm_acc_in_ready_o  = w_in_ready;
    assign intrm_acc_out_valid_o = r_out_valid;
    assign intrm_acc_out_o       = r_out;
    assign intrm_acc_beat_cnt_o  = r_beat_cnt;
    assign intrm_acc_ovf_o       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_conv_intrm_acc_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_intrm_acc_buf
// Description : Bench for conv_intrm_acc_buf; three parameterisations share
//               one stimulus stream and are checked against a sum model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_intrm_acc_buf;

    localparam int NCH = 5;
    localparam int IW  = 32;
    localparam int ACC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, en, mode, in_valid, out_ready;
    logic [NCH*IW-1:0] in_bus;

    logic         rdy_s64, rdy_u64, rdy_s32;
    logic         vld_s64, vld_u64, vld_s32;
    logic [1:0]   cnt_s64, cnt_u64, cnt_s32;
    logic         ovf_s64, ovf_u64, ovf_s32;
    logic [319:0] out_s64, out_u64;
    logic [159:0] out_s32;

    conv_intrm_acc_buf #(.NUM_INPUTS(NCH), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(64),
                         .ACC_LEN(ACC), .SIGNED(1)) u_dut_s64 (
        .intrm_acc_clk(clk), .intrm_acc_rst(rst), .intrm_acc_en_i(en),
        .intrm_acc_mode_i(mode), .intrm_acc_in_valid_i(in_valid),
        .intrm_acc_in_ready_o(rdy_s64), .intrm_acc_in_i(in_bus),
        .intrm_acc_out_valid_o(vld_s64), .intrm_acc_out_ready_i(out_ready),
        .intrm_acc_out_o(out_s64), .intrm_acc_beat_cnt_o(cnt_s64),
        .intrm_acc_ovf_o(ovf_s64));

    conv_intrm_acc_buf #(.NUM_INPUTS(NCH), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(64),
                         .ACC_LEN(ACC), .SIGNED(0)) u_dut_u64 (
        .intrm_acc_clk(clk), .intrm_acc_rst(rst), .intrm_acc_en_i(en),
        .intrm_acc_mode_i(mode), .intrm_acc_in_valid_i(in_valid),
        .intrm_acc_in_ready_o(rdy_u64), .intrm_acc_in_i(in_bus),
        .intrm_acc_out_valid_o(vld_u64), .intrm_acc_out_ready_i(out_ready),
        .intrm_acc_out_o(out_u64), .intrm_acc_beat_cnt_o(cnt_u64),
        .intrm_acc_ovf_o(ovf_u64));

    conv_intrm_acc_buf #(.NUM_INPUTS(NCH), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(32),
                         .ACC_LEN(ACC), .SIGNED(1)) u_dut_s32 (
        .intrm_acc_clk(clk), .intrm_acc_rst(rst), .intrm_acc_en_i(en),
        .intrm_acc_mode_i(mode), .intrm_acc_in_valid_i(in_valid),
        .intrm_acc_in_ready_o(rdy_s32), .intrm_acc_in_i(in_bus),
        .intrm_acc_out_valid_o(vld_s32), .intrm_acc_out_ready_i(out_ready),
        .intrm_acc_out_o(out_s32), .intrm_acc_beat_cnt_o(cnt_s32),
        .intrm_acc_ovf_o(ovf_s32));

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    int cfg_ow [3] = '{64, 64, 32};
    bit cfg_sg [3] = '{1'b1, 1'b0, 1'b1};

    // Reference state: per configuration, group progress and the results.
    int          m_cnt   [3];
    bit          m_mode  [3];
    bit          m_valid [3];
    bit          m_ovf   [3];
    logic [63:0] m_acc   [3][NCH];
    logic [63:0] m_out   [3][NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] act_out(input int k, input int ch);
        case (k)
            0:       return out_s64[ch*64 +: 64];
            1:       return out_u64[ch*64 +: 64];
            default: return {32'b0, out_s32[ch*32 +: 32]};
        endcase
    endfunction

    function automatic logic [3:0] act_flags(input int k);
        case (k)
            0:       return {rdy_s64, vld_s64, ovf_s64, 1'b0};
            1:       return {rdy_u64, vld_u64, ovf_u64, 1'b0};
            default: return {rdy_s32, vld_s32, ovf_s32, 1'b0};
        endcase
    endfunction

    function automatic logic [1:0] act_cnt(input int k);
        case (k)
            0:       return cnt_s64;
            1:       return cnt_u64;
            default: return cnt_s32;
        endcase
    endfunction

    function automatic bit m_final(input int k);
        bit md;
        md = (m_cnt[k] == 0) ? mode : m_mode[k];
        return !md || (m_cnt[k] == ACC - 1);
    endfunction

    function automatic bit exp_ready(input int k);
        return en && !rst && (!m_final(k) || !m_valid[k] || out_ready);
    endfunction

    function automatic logic [63:0] mext(input logic [31:0] x, input int ow, input bit sg);
        if (ow == 32) return {32'b0, x};
        return sg ? {{32{x[31]}}, x} : {32'b0, x};
    endfunction

    // Exact-integer add, then range test against the output width.
    task automatic madd(input logic [63:0] a, input logic [63:0] b, input int ow,
                        input bit sg, output logic [63:0] s, output bit ov);
        logic signed [65:0] ta, tb, tv, lim;
        if (ow == 64) begin
            ta = sg ? {{2{a[63]}}, a} : {2'b0, a};
            tb = sg ? {{2{b[63]}}, b} : {2'b0, b};
        end else begin
            ta = sg ? {{34{a[31]}}, a[31:0]} : {34'b0, a[31:0]};
            tb = sg ? {{34{b[31]}}, b[31:0]} : {34'b0, b[31:0]};
        end
        tv  = ta + tb;
        lim = 66'sd1 <<< (ow - 1);
        if (sg) ov = (tv >= lim) || (tv < -lim);
        else    ov = (tv >= (lim <<< 1));
        s = (ow == 64) ? tv[63:0] : {32'b0, tv[31:0]};
    endtask

    task automatic model_step(input int k);
        bit          go, fin, first, ov;
        logic [63:0] e, base, s;
        if (rst) begin
            m_cnt[k] = 0; m_mode[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                m_acc[k][ch] = '0;
                m_out[k][ch] = '0;
            end
        end else begin
            go    = in_valid && exp_ready(k);
            fin   = m_final(k);
            first = (m_cnt[k] == 0);
            if (go) begin
                if (first) m_mode[k] = mode;
                for (int ch = 0; ch < NCH; ch++) begin
                    e    = mext(in_bus[ch*32 +: 32], cfg_ow[k], cfg_sg[k]);
                    base = first ? 64'd0 : m_acc[k][ch];
                    madd(base, e, cfg_ow[k], cfg_sg[k], s, ov);
                    if (ov) m_ovf[k] = 1'b1;
                    if (fin) m_out[k][ch] = s;
                    else     m_acc[k][ch] = s;
                end
                m_cnt[k] = fin ? 0 : m_cnt[k] + 1;
            end
            if (go && fin)      m_valid[k] = 1'b1;
            else if (out_ready) m_valid[k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d_in_ready", k), 64'(act_flags(k)[3]), 64'(exp_ready(k)));
                chk($sformatf("d%0d_out_valid", k), 64'(act_flags(k)[2]), 64'(m_valid[k]));
                chk($sformatf("d%0d_ovf", k), 64'(act_flags(k)[1]), 64'(m_ovf[k]));
                chk($sformatf("d%0d_beat_cnt", k), 64'(act_cnt(k)), 64'(m_cnt[k]));
                for (int ch = 0; ch < NCH; ch++)
                    chk($sformatf("d%0d_out%0d", k, ch), act_out(k, ch), m_out[k][ch]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d0, input logic [31:0] d4, input bit md);
        bit ok;
        in_bus          = '0;
        in_bus[31:0]    = d0;
        in_bus[159:128] = d4;
        mode            = md;
        in_valid        = 1'b1;
        ok              = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (exp_ready(0)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("beat_accept_timeout", 64'(ok), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_bus = '0;
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(rdy_s64), 64'd0);
        chk("rst_out_valid", 64'(vld_s64), 64'd0);
        chk("rst_beat_cnt", 64'(cnt_s64), 64'd0);
        chk("rst_ovf", 64'(ovf_s64), 64'd0);
        chk("rst_out0", act_out(0, 0), 64'd0);
        step();

        // Mode 0 extension
        rst = 1'b0;
        in_bus[31:0]  = 32'haaaa_aaaa;
        in_bus[63:32] = 32'h1111_1111;
        @(negedge clk);
        chk("first_accept_ready", 64'(rdy_s64), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("m0_s64_out0", act_out(0, 0), 64'hffff_ffff_aaaa_aaaa);
        chk("m0_s64_out1", act_out(0, 1), 64'h0000_0000_1111_1111);
        chk("m0_u64_out0", act_out(1, 0), 64'h0000_0000_aaaa_aaaa);
        chk("m0_s32_out0", act_out(2, 0), 64'h0000_0000_aaaa_aaaa);
        chk("m0_out_valid", 64'(vld_s64), 64'd1);
        step();

        // Mode 1 accumulate
        send_beat(32'h1111_1111, 32'h0, 1'b1);
        @(negedge clk); chk("acc_cnt1", 64'(cnt_s64), 64'd1); step();
        send_beat(32'h2222_2222, 32'h0, 1'b1);
        @(negedge clk); chk("acc_cnt2", 64'(cnt_s64), 64'd2); step();
        send_beat(32'h3333_3333, 32'h0, 1'b1);
        @(negedge clk);
        chk("acc_cnt0", 64'(cnt_s64), 64'd0);
        chk("acc_s64_out0", act_out(0, 0), 64'h0000_0000_6666_6666);
        step();
        for (int i = 0; i < 3; i++) send_beat(32'h0, 32'hffff_ffff, 1'b1);
        @(negedge clk);
        chk("acc_s64_out4", act_out(0, 4), 64'hffff_ffff_ffff_fffd);
        chk("acc_u64_out4", act_out(1, 4), 64'h0000_0002_ffff_fffd);
        chk("acc_s32_out4", act_out(2, 4), 64'h0000_0000_ffff_fffd);
        step();

        // Backpressure
        out_ready = 1'b0;
        send_beat(32'h0000_abcd, 32'h0, 1'b0);
        in_bus       = '0;
        in_bus[31:0] = 32'h0000_1234;
        in_valid     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(rdy_s64), 64'd0);
            chk("bp_out0_hold", act_out(0, 0), 64'h0000_0000_0000_abcd);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(rdy_s64), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_out0", act_out(0, 0), 64'h0000_0000_0000_1234);
        chk("bp_valid_stays", 64'(vld_s64), 64'd1);
        step();

        // Enable low and mode toggling mid-group
        send_beat(32'd5, 32'h0, 1'b1);
        @(negedge clk); chk("en_cnt1", 64'(cnt_s64), 64'd1); step();
        en = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mode = ~mode;
            @(negedge clk);
            chk("en_low_cnt", 64'(cnt_s64), 64'd1);
            chk("en_low_ready", 64'(rdy_s64), 64'd0);
            step();
        end
        en = 1'b1;
        send_beat(32'd6, 32'h0, 1'b0);
        @(negedge clk); chk("en_cnt2", 64'(cnt_s64), 64'd2); step();
        send_beat(32'd7, 32'h0, 1'b0);
        @(negedge clk);
        chk("en_sum_out0", act_out(0, 0), 64'd18);
        chk("en_sum_cnt", 64'(cnt_s64), 64'd0);
        step();

        // Reset mid-group, then signed overflow on the 32-bit instance
        send_beat(32'd1, 32'h0, 1'b1);
        send_beat(32'd2, 32'h0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cnt", 64'(cnt_s64), 64'd0);
        chk("midrst_valid", 64'(vld_s64), 64'd0);
        step();
        send_beat(32'h7fff_ffff, 32'h0, 1'b1);
        send_beat(32'h0000_0001, 32'h0, 1'b1);
        send_beat(32'h0000_0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("ovf_s32_out0", act_out(2, 0), 64'h0000_0000_8000_0000);
        chk("ovf_s32_flag", 64'(ovf_s32), 64'd1);
        chk("ovf_s64_flag", 64'(ovf_s64), 64'd0);
        chk("ovf_s64_out0", act_out(0, 0), 64'h0000_0000_8000_0000);
        step();
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        chk("ovf_sticky", 64'(ovf_s32), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 64'(ovf_s32), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_intrm_acc_buf.md
Name: conv_intrm_acc_buf

Overview:
Parametrised intermediate buffer/accumulator sitting between the conv multiplier array and the next conv/pool stage. It takes NUM_INPUTS channels of INPUT_WIDTH products and extends each to OUTPUT_WIDTH (sign or zero). It works in one of two modes: pass-through (one output per input beat) or accumulate (sums ACC_LEN consecutive beats per channel into one partial-sum output). Valid/ready handshakes sit on both sides, with single-entry output holding under backpressure.

Parameters:
NUM_INPUTS, 5, number of parallel channels
INPUT_WIDTH, 32, bits per input channel
OUTPUT_WIDTH, 2*INPUT_WIDTH, bits per output channel; must be >= INPUT_WIDTH
ACC_LEN, 5, beats per accumulation group in mode 1; must be >= 2
SIGNED, 1, 1 = sign-extend and signed add/overflow; 0 = zero-extend, unsigned

Ports:
intrm_acc_clk  input  1  clock, all state on rising edge
intrm_acc_rst  input  1  synchronous active-high reset
intrm_acc_en_i  input  1  input-side enable; low = no beat accepted, accumulators frozen
intrm_acc_mode_i  input  1  0 = pass/extend, 1 = accumulate; sampled at first beat of a group
intrm_acc_in_valid_i  input  1  input beat valid
intrm_acc_in_ready_o  output  1  input beat can be accepted
intrm_acc_in_i  input  NUM_INPUTS*INPUT_WIDTH  packed channels, [ch][bit]
intrm_acc_out_valid_o  output  1  output register holds result
intrm_acc_out_ready_i  input  1  downstream accepts result
intrm_acc_out_o  output  NUM_INPUTS*OUTPUT_WIDTH  packed results, [ch][bit]
intrm_acc_beat_cnt_o  output  $clog2(ACC_LEN)  beats accepted in current group
intrm_acc_ovf_o  output  1  sticky overflow flag, any channel

Behaviour:
- Reset has priority over all other inputs. While intrm_acc_rst is high at an edge, the following are all cleared to 0: out_o, out_valid_o, beat_cnt_o, ovf_o, accumulators and latched mode. in_ready_o is forced 0 while rst is high.
- Accept condition: in_valid_i & in_ready_o.
- Final beat: the latched/effective mode is 0, or beat_cnt == ACC_LEN-1.
- in_ready_o = en_i & !rst & (!final_beat | !out_valid_o | out_ready_i). This is combinational. Non-final beats in mode 1 are never blocked by the output.
- Mode latch: mode_i is captured on the accepted beat when beat_cnt==0. Changes to mode_i mid-group are ignored until the group completes.
- Extension: ext(x) = SIGNED ? sign-extend : zero-extend. If OUTPUT_WIDTH == INPUT_WIDTH, ext is identity.
- Mode 0: on an accepted beat, out_o[ch] <= ext(in_i[ch]) and out_valid_o <= 1. beat_cnt stays 0. Latency is 1 cycle.
- Mode 1:
  - First beat loads acc[ch] <= ext(in_i[ch]).
  - Later beats do acc[ch] <= acc[ch] + ext(in_i[ch]), wrapping modulo 2^OUTPUT_WIDTH.
  - beat_cnt increments on each accepted beat.
  - On the final beat: out_o[ch] <= acc[ch] + ext(in_i[ch]), out_valid_o <= 1, beat_cnt <= 0.
  - The result is visible 1 cycle after the final-beat edge.
- Overflow:
  - SIGNED=1: signed overflow of any channel add sets ovf_o.
  - SIGNED=0: carry-out of any channel add sets ovf_o.
  - ovf_o is sticky and cleared only by reset.
  - With the default widths overflow cannot occur.
- Output handshake:
  - If out_valid_o & out_ready_i with no new result that cycle, then out_valid_o <= 0 next cycle. out_o holds its last value.
  - If a result is produced in the same cycle as the output handshake, out_o is replaced and out_valid_o stays 1.
  - While out_valid_o & !out_ready_i, out_o is stable.
- en_i low: no beats are accepted and acc/beat_cnt hold. The output handshake still completes normally.
- Reset mid-group discards the partial sum. The next accepted beat starts a new group with freshly latched mode.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_o=0, out_valid=0, in_ready=0, beat_cnt=0, ovf=0. First accept occurs on the cycle after rst falls.
- Mode 0 extension (SIGNED=1, out_ready=1): in[0]=32'haaaa_aaaa, in[1]=32'h1111_1111 -> next cycle out[0]=64'hffff_ffff_aaaa_aaaa, out[1]=64'h0000_0000_1111_1111, out_valid=1. Repeat with SIGNED=0 -> out[0]=64'h0000_0000_aaaa_aaaa.
- Mode 1 accumulate (ACC_LEN=3): ch0 beats 32'h1111_1111, 32'h2222_2222, 32'h3333_3333 -> beat_cnt 1,2,0. Cycle after third beat: out[0]=64'h0000_0000_6666_6666. In a second group, ch4 beats of 32'hffff_ffff x3 -> out[4]=64'hffff_ffff_ffff_fffd.
- Backpressure: hold out_ready=0 with out_valid=1 and present a final beat -> in_ready=0 and out_o unchanged for 10 cycles. Raise out_ready -> beat accepted the same cycle, new result the next cycle, out_valid stays 1.
- Enable/mode change mid-group: accept 1 beat (mode 1), drop en_i for 5 cycles and toggle mode_i -> beat_cnt stays 1 and in_ready=0. Resume -> the group completes in mode 1 with the correct sum.
- Reset mid-group + overflow (OUTPUT_WIDTH=32, SIGNED=1):
  - After 2 beats, pulse rst for 1 cycle -> beat_cnt=0, out_valid=0.
  - Then beats 32'h7fff_ffff, 32'h0000_0001, 0 -> out[0]=32'h8000_0000, ovf=1. ovf holds until the next reset.
